// File: rtl/yolo_frame_loader_if.sv
// Handshake bundle between an activation source, yolo_frame_loader and the conv stage.
// Optional YOLO_LOADER_LAST_CHECK_EN adds in_last / frame_err.
interface yolo_frame_loader_if #(
  parameter int WIDTH = 16,
  parameter int N     = 1
);
  localparam int CNT_W = $clog2(N + 1);

  logic signed [WIDTH-1:0]   in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic        [N*WIDTH-1:0] frame_vec;
  logic                      frame_valid;
  logic                      frame_ready;
  logic        [CNT_W-1:0]   fill_count;
`ifdef YOLO_LOADER_LAST_CHECK_EN
  logic                      in_last;
  logic                      frame_err;

  modport master (output in_data, in_valid, in_last, frame_ready,
                  input  in_ready, frame_vec, frame_valid, fill_count, frame_err);
  modport slave  (input  in_data, in_valid, in_last, frame_ready,
                  output in_ready, frame_vec, frame_valid, fill_count, frame_err);
`else
  modport master (output in_data, in_valid, frame_ready,
                  input  in_ready, frame_vec, frame_valid, fill_count);
  modport slave  (input  in_data, in_valid, frame_ready,
                  output in_ready, frame_vec, frame_valid, fill_count);
`endif
endinterface

// File: rtl/yolo_frame_loader.sv
// Assembles a streamed IN_CH x IN_H x IN_W activation tensor into a flat vector for yolo_conv.
// Define YOLO_LOADER_LAST_CHECK_EN to enable in_last framing checks (sticky frame_err).
module yolo_frame_loader #(
  parameter int IN_CH = 1,
  parameter int IN_H  = 1,
  parameter int IN_W  = 1,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  yolo_frame_loader_if.slave    bus
);
  localparam int N     = IN_CH * IN_H * IN_W;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {FILL, FULL} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               frame_valid_q, frame_valid_d;
  logic [CNT_W-1:0]   fill_count_q, fill_count_d;
  logic [N*WIDTH-1:0] frame_vec_q, frame_vec_d;
  logic               accept;
  logic               is_last;

  assign accept  = (state_q == FILL) && in_ready_q && bus.in_valid;
  assign is_last = (fill_count_q == CNT_W'(N - 1));

  // NOTE: every _d starts from its _q so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    frame_valid_d = frame_valid_q;
    fill_count_d  = fill_count_q;
    frame_vec_d   = frame_vec_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          frame_vec_d[int'(fill_count_q)*WIDTH +: WIDTH] = bus.in_data;
          fill_count_d = fill_count_q + CNT_W'(1);
          if (is_last) begin
            state_d       = FULL;
            in_ready_d    = 1'b0;
            frame_valid_d = 1'b1;
          end
        end
      end
      FULL: begin
        // Ack only releases the frame; no word is taken on the same edge.
        if (bus.frame_ready && frame_valid_q) begin
          state_d       = FILL;
          in_ready_d    = 1'b1;
          frame_valid_d = 1'b0;
          fill_count_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the frame buffer is reset too, so frame_vec reads zero straight out of reset.
  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      fill_count_q  <= '0;
      frame_vec_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      fill_count_q  <= fill_count_d;
      frame_vec_q   <= frame_vec_d;
    end
  end

  // in_ready flop resets high; it is masked only while reset is held.
  assign bus.in_ready    = in_ready_q & rst_n;
  assign bus.frame_valid = frame_valid_q;
  assign bus.fill_count  = fill_count_q;
  assign bus.frame_vec   = frame_vec_q;

`ifdef YOLO_LOADER_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  // Sticky: in_last must be high exactly on element N-1.
  always_comb begin
    frame_err_d = frame_err_q;
    if (accept && (bus.in_last != is_last)) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign bus.frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_yolo_frame_loader.sv
// Directed self-checking bench for yolo_frame_loader in three geometries (2x2, 2ch x 1x2, 1x1x1).
module tb_yolo_frame_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  yolo_frame_loader_if #(.WIDTH(16), .N(4)) if_a ();
  yolo_frame_loader_if #(.WIDTH(16), .N(4)) if_b ();
  yolo_frame_loader_if #(.WIDTH(16), .N(1)) if_c ();

  yolo_frame_loader #(.IN_CH(1), .IN_H(2), .IN_W(2), .WIDTH(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  yolo_frame_loader #(.IN_CH(2), .IN_H(1), .IN_W(2), .WIDTH(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  yolo_frame_loader #(.IN_CH(1), .IN_H(1), .IN_W(1), .WIDTH(16)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] d, input logic last);
    if_a.in_valid = v;
    if_a.in_data  = d;
`ifdef YOLO_LOADER_LAST_CHECK_EN
    if_a.in_last  = last;
`else
    if (last) begin end
`endif
  endtask

  initial begin
    logic [63:0] vec_a;
    logic [6:0]  pat;
    int          k;

    rst_n = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    if_a.frame_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.frame_ready = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.frame_ready = 1'b0;
`ifdef YOLO_LOADER_LAST_CHECK_EN
    if_b.in_last = 1'b0;
    if_c.in_last = 1'b1;
`endif

    // Reset values, while held and just after release
    #3;
    check("rst_in_ready_held", if_a.in_ready, 1'b0);
    check("rst_frame_valid", if_a.frame_valid, 1'b0);
    check("rst_fill_count", if_a.fill_count, 3'd0);
    check("rst_frame_vec", if_a.frame_vec, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", if_a.in_ready, 1'b1);

    // Fill 2x2 frame with in_valid held high
    drive_a(1'b1, 16'h0100, 1'b0); step();
    check("a_fill1", if_a.fill_count, 3'd1);
    check("a_notvalid1", if_a.frame_valid, 1'b0);
    drive_a(1'b1, 16'h0200, 1'b0); step();
    drive_a(1'b1, 16'hFF00, 1'b0); step();
    check("a_fill3", if_a.fill_count, 3'd3);
    check("a_ready3", if_a.in_ready, 1'b1);
    drive_a(1'b1, 16'h0080, 1'b1); step();
    check("a_full_valid", if_a.frame_valid, 1'b1);
    check("a_full_ready", if_a.in_ready, 1'b0);
    check("a_full_vec", if_a.frame_vec, 64'h0080_FF00_0200_0100);
    check("a_full_count", if_a.fill_count, 3'd4);

    // Hold FULL with in_valid high and changing data
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 16'h1000 + 16'(i), 1'b0);
      step();
      check("a_hold_vec", if_a.frame_vec, 64'h0080_FF00_0200_0100);
    end
    check("a_hold_count", if_a.fill_count, 3'd4);
    drive_a(1'b0, '0, 1'b0);
    if_a.frame_ready = 1'b1;
    step();
    if_a.frame_ready = 1'b0;
    check("a_ack_valid", if_a.frame_valid, 1'b0);
    check("a_ack_ready", if_a.in_ready, 1'b1);
    check("a_ack_count", if_a.fill_count, 3'd0);
    check("a_ack_vec_kept", if_a.frame_vec, 64'h0080_FF00_0200_0100);

    // frame_ready while filling must be ignored
    if_a.frame_ready = 1'b1;
    drive_a(1'b1, 16'h0A0A, 1'b0); step();
    if_a.frame_ready = 1'b0;
    check("a_fill_ack_ignored", if_a.fill_count, 3'd1);
    check("a_fill_ack_ready", if_a.in_ready, 1'b1);
    drive_a(1'b1, 16'h0B0B, 1'b0); step();
    drive_a(1'b0, '0, 1'b0);

    // Asynchronous reset after two words, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", if_a.fill_count, 3'd0);
    check("arst_vec", if_a.frame_vec, 64'd0);
    check("arst_valid", if_a.frame_valid, 1'b0);
    check("arst_ready", if_a.in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    check("arst_rel_ready", if_a.in_ready, 1'b1);
    drive_a(1'b1, 16'h000A, 1'b0); step();
    drive_a(1'b1, 16'h000B, 1'b0); step();
    drive_a(1'b1, 16'h000C, 1'b0); step();
    drive_a(1'b1, 16'h000D, 1'b1); step();
    drive_a(1'b0, '0, 1'b0);
    check("arst_frame_valid", if_a.frame_valid, 1'b1);
    check("arst_frame_vec", if_a.frame_vec, 64'h000D_000C_000B_000A);
`ifdef YOLO_LOADER_LAST_CHECK_EN
    check("err_clean", if_a.frame_err, 1'b0);
`endif
    if_a.frame_ready = 1'b1; step(); if_a.frame_ready = 1'b0;

    // 2ch x 1x2 with valid gaps; slot pattern bit0 first: 1,0,1,0,0,1,1
    pat = 7'b1100101;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if_b.in_valid = pat[i];
      if_b.in_data  = pat[i] ? 16'(k + 1) : 16'hDEAD;
`ifdef YOLO_LOADER_LAST_CHECK_EN
      if_b.in_last  = pat[i] && (k == 3);
`endif
      step();
      if (pat[i]) k++;
      check("b_fill_count", if_b.fill_count, 64'(k));
    end
    if_b.in_valid = 1'b0;
    vec_a = if_b.frame_vec;
    check("b_valid", if_b.frame_valid, 1'b1);
    check("b_elem2", vec_a[32 +: 16], 16'd3);
    check("b_vec", vec_a, 64'h0004_0003_0002_0001);

    // N=1 with frame_ready held high
    if_c.frame_ready = 1'b1;
    if_c.in_valid = 1'b1; if_c.in_data = 16'h7FFF;
    step();
    check("c_f1_valid", if_c.frame_valid, 1'b1);
    check("c_f1_vec", if_c.frame_vec, 16'h7FFF);
    check("c_f1_ready", if_c.in_ready, 1'b0);
    check("c_f1_count", if_c.fill_count, 1'd1);
    if_c.in_data = 16'h8000;
    step();
    check("c_ack_valid", if_c.frame_valid, 1'b0);
    check("c_ack_ready", if_c.in_ready, 1'b1);
    check("c_ack_vec", if_c.frame_vec, 16'h7FFF);
    step();
    if_c.in_valid = 1'b0;
    check("c_f2_valid", if_c.frame_valid, 1'b1);
    check("c_f2_vec", if_c.frame_vec, 16'h8000);
    check("c_f2_ready", if_c.in_ready, 1'b0);
    step();
    check("c_f2_ack_ready", if_c.in_ready, 1'b1);
    if_c.frame_ready = 1'b0;

    // in_last on word 2 of a 4-word frame
    drive_a(1'b1, 16'h0011, 1'b0); step();
    drive_a(1'b1, 16'h0022, 1'b1); step();
`ifdef YOLO_LOADER_LAST_CHECK_EN
    check("err_set", if_a.frame_err, 1'b1);
`endif
    drive_a(1'b1, 16'h0033, 1'b0); step();
    drive_a(1'b1, 16'h0044, 1'b0); step();
    drive_a(1'b0, '0, 1'b0);
    check("last_frame_valid", if_a.frame_valid, 1'b1);
    check("last_frame_vec", if_a.frame_vec, 64'h0044_0033_0022_0011);
    if_a.frame_ready = 1'b1; step(); if_a.frame_ready = 1'b0;
    step();
`ifdef YOLO_LOADER_LAST_CHECK_EN
    check("err_sticky", if_a.frame_err, 1'b1);
`endif
    check("last_ack_ready", if_a.in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
